// File: rtl/tv_sequencer.sv
// Test-vector sequencer. It fetches each vector from a synchronous ROM, applies it to the DUT
// with a one-cycle step, waits a settle time, and hands the captured DUT output to the uploader.
module tv_sequencer #(
    parameter int INPUT_WIDTH   = 16,
    parameter int OUTPUT_WIDTH  = 8,
    parameter int N_TV          = 256,
    parameter int LOG_N_TV      = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic [LOG_N_TV-1:0]     tv_addr,
    input  logic [INPUT_WIDTH-1:0]  tv_data,
    output logic [INPUT_WIDTH-1:0]  dut_in,
    output logic                    dut_step,
    input  logic [OUTPUT_WIDTH-1:0] dut_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUTPUT_WIDTH-1:0] res_data,
    output logic [LOG_N_TV-1:0]     res_index,
    output logic                    busy,
    output logic                    done
);

    localparam int SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    localparam logic [LOG_N_TV-1:0] LAST_INDEX  = LOG_N_TV'(N_TV - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_STOP = SETTLE_W'(SETTLE_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_SETTLE,
        S_RESULT,
        S_DONE
    } state_t;

    state_t              state;
    logic [LOG_N_TV-1:0] index;
    logic [SETTLE_W-1:0] settle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            index      <= '0;
            settle_cnt <= '0;
            tv_addr    <= '0;
            dut_in     <= '0;
            dut_step   <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_index  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dut_step <= 1'b0;
            done     <= 1'b0;
            // abort outranks every transition, including a handshake in the same cycle
            if (abort) begin
                state     <= S_IDLE;
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_FETCH;
                            index   <= '0;
                            tv_addr <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        dut_in   <= tv_data;
                        dut_step <= 1'b1;
                        state    <= S_APPLY;
                    end
                    S_APPLY: begin
                        if (SETTLE_CYCLES > 0) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                        end else begin
                            state     <= S_RESULT;
                            res_valid <= 1'b1;
                            res_data  <= dut_out;
                            res_index <= index;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_STOP) begin
                            state     <= S_RESULT;
                            res_valid <= 1'b1;
                            res_data  <= dut_out;
                            res_index <= index;
                        end else begin
                            settle_cnt <= settle_cnt + SETTLE_W'(1);
                        end
                    end
                    S_RESULT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            if (index == LAST_INDEX) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                index   <= index + LOG_N_TV'(1);
                                tv_addr <= index + LOG_N_TV'(1);
                                state   <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tv_sequencer.sv
// Bench for tv_sequencer. It runs two instances side by side: one with a settle time of 2 and
// one with a settle time of 0. A vector-level reference model is checked every cycle, alongside directed scenarios.
module tb_tv_sequencer;

    localparam int NTV = 4;

    logic clk;
    logic reset     = 1'b1;
    logic start     = 1'b0;
    logic abort     = 1'b0;
    logic res_ready = 1'b1;

    logic [1:0][7:0]  tv_addr_v, res_data_v, res_index_v, dut_out_v;
    logic [1:0][15:0] tv_data_v, dut_in_v;
    logic [1:0]       dut_step_v, res_valid_v, busy_v, done_v;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    string  rq_name[128];
    longint rq_act[128];
    longint rq_exp[128];
    int     rq_wr = 0;
    int     rq_rd = 0;

    int exp_lo[4] = '{10, 20, 30, 40};

    function automatic logic [15:0] rom_word(input int i);
        case (i)
            0:       return 16'h120A;
            1:       return 16'h3414;
            2:       return 16'h561E;
            3:       return 16'h7828;
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    tv_sequencer #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .N_TV(NTV), .LOG_N_TV(8), .SETTLE_CYCLES(2)) u_seq2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .tv_addr(tv_addr_v[0]), .tv_data(tv_data_v[0]), .dut_in(dut_in_v[0]), .dut_step(dut_step_v[0]),
        .dut_out(dut_out_v[0]), .res_valid(res_valid_v[0]), .res_ready(res_ready),
        .res_data(res_data_v[0]), .res_index(res_index_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    tv_sequencer #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .N_TV(NTV), .LOG_N_TV(8), .SETTLE_CYCLES(0)) u_seq0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .tv_addr(tv_addr_v[1]), .tv_data(tv_data_v[1]), .dut_in(dut_in_v[1]), .dut_step(dut_step_v[1]),
        .dut_out(dut_out_v[1]), .res_valid(res_valid_v[1]), .res_ready(res_ready),
        .res_data(res_data_v[1]), .res_index(res_index_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    // ROM with a registered address inside the sequencer; the DUT echoes its input low byte
    assign tv_data_v[0] = rom_word(int'(tv_addr_v[0]));
    assign tv_data_v[1] = rom_word(int'(tv_addr_v[1]));
    assign dut_out_v[0] = dut_in_v[0][7:0];
    assign dut_out_v[1] = dut_in_v[1][7:0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each run is a list of vectors; m_age is the number of cycles spent on the current vector
    logic       m_active[2];
    logic       m_donecyc[2];
    int         m_idx[2];
    int         m_age[2];
    logic [7:0]  m_tv_addr[2];
    logic [15:0] m_dut_in[2];
    logic [7:0]  m_res_data[2];
    logic [7:0]  m_res_index[2];

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_active[k] <= 1'b0; m_donecyc[k] <= 1'b0; m_idx[k] <= 0; m_age[k] <= 0;
                m_tv_addr[k] <= 8'd0; m_dut_in[k] <= 16'd0; m_res_data[k] <= 8'd0; m_res_index[k] <= 8'd0;
            end else if (abort) begin
                m_active[k]  <= 1'b0;
                m_donecyc[k] <= 1'b0;
            end else if (m_donecyc[k]) begin
                m_donecyc[k] <= 1'b0;
            end else if (!m_active[k]) begin
                if (start) begin
                    m_active[k] <= 1'b1; m_idx[k] <= 0; m_age[k] <= 0; m_tv_addr[k] <= 8'd0;
                end
            end else if (m_age[k] >= 2 + settle_of(k)) begin
                if (res_ready) begin
                    if (m_idx[k] == NTV - 1) begin
                        m_active[k]  <= 1'b0;
                        m_donecyc[k] <= 1'b1;
                    end else begin
                        m_idx[k]     <= m_idx[k] + 1;
                        m_tv_addr[k] <= 8'(m_idx[k] + 1);
                        m_age[k]     <= 0;
                    end
                end
            end else begin
                m_age[k] <= m_age[k] + 1;
                if (m_age[k] == 0) m_dut_in[k] <= rom_word(m_idx[k]);
                if (m_age[k] + 1 == 2 + settle_of(k)) begin
                    m_res_data[k]  <= 8'(rom_word(m_idx[k]));
                    m_res_index[k] <= 8'(m_idx[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Single checking process: model comparison every cycle, plus literal checks posted by the stimulus
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.tv_addr", k),   longint'(tv_addr_v[k]),   longint'(m_tv_addr[k]));
                chk($sformatf("u%0d.dut_in", k),    longint'(dut_in_v[k]),    longint'(m_dut_in[k]));
                chk($sformatf("u%0d.dut_step", k),  longint'(dut_step_v[k]),  longint'(m_active[k] && m_age[k] == 1));
                chk($sformatf("u%0d.res_valid", k), longint'(res_valid_v[k]),
                    longint'(m_active[k] && m_age[k] >= 2 + settle_of(k)));
                chk($sformatf("u%0d.res_data", k),  longint'(res_data_v[k]),  longint'(m_res_data[k]));
                chk($sformatf("u%0d.res_index", k), longint'(res_index_v[k]), longint'(m_res_index[k]));
                chk($sformatf("u%0d.busy", k),      longint'(busy_v[k]),      longint'(m_active[k] || m_donecyc[k]));
                chk($sformatf("u%0d.done", k),      longint'(done_v[k]),      longint'(m_donecyc[k]));
            end
            while (rq_rd < rq_wr) begin
                chk(rq_name[rq_rd], rq_act[rq_rd], rq_exp[rq_rd]);
                rq_rd++;
            end
        end
    end

    task automatic push(input string nm, input longint act, input longint exp);
        if (rq_wr < 128) begin
            rq_name[rq_wr] = nm;
            rq_act[rq_wr]  = act;
            rq_exp[rq_wr]  = exp;
            rq_wr++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input logic [7:0] idx, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (res_valid_v[0] && res_index_v[0] == idx) ok = 1'b1;
            else step();
        end
        if (!ok) push({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input int ts, input int exp_dt, input string nm);
        bit got = 1'b0;
        int dt = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (done_v[0]) begin
                got = 1'b1;
                dt  = cyc - ts;
            end
        end
        if (!got) push({nm, "_timeout"}, 0, 1);
        else push(nm, dt, exp_dt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ts, dt, ns, nres, nd, k1, st1a, st1b, bad, nst;
        bit got0, got1, prev1;
        logic [7:0] rd[4];
        logic [7:0] ri[4];

        // Reset state
        repeat (3) step();
        push("rst_busy", busy_v[0], 0);
        push("rst_res_valid", res_valid_v[0], 0);
        push("rst_tv_addr", tv_addr_v[0], 0);
        reset = 1'b0;
        step();

        // Full run with res_ready high; the zero-settle instance runs alongside
        start = 1'b1; step(); ts = cyc; start = 1'b0;
        got0 = 0; got1 = 0; prev1 = 0; ns = 0; nres = 0; k1 = 0; st1a = -1; st1b = -1; dt = 0;
        for (int i = 0; i < 40 && !got0; i++) begin
            if (res_valid_v[0]) begin
                if (nres < 4) begin rd[nres] = res_data_v[0]; ri[nres] = res_index_v[0]; end
                nres++;
            end
            if (dut_step_v[0]) ns++;
            if (prev1 && k1 < 4) begin
                push($sformatf("s0_valid_after_step%0d", k1), res_valid_v[1], 1);
                push($sformatf("s0_data%0d", k1), res_data_v[1], exp_lo[k1]);
                k1++;
            end
            prev1 = dut_step_v[1];
            if (dut_step_v[1]) begin
                if (st1a < 0) st1a = cyc;
                else if (st1b < 0) st1b = cyc;
            end
            if (done_v[1] && !got1) begin got1 = 1; push("s0_done_at", cyc - ts, 12); end
            step();
            if (done_v[0]) begin got0 = 1; dt = cyc - ts; end
        end
        if (!got0) push("t1_done_timeout", 0, 1);
        else push("t1_done_at", dt, 20);
        push("t1_steps", ns, 4);
        push("t1_results", nres, 4);
        for (int k = 0; k < 4; k++) begin
            push($sformatf("t1_data%0d", k), rd[k], exp_lo[k]);
            push($sformatf("t1_index%0d", k), ri[k], k);
        end
        push("s0_period", st1b - st1a, 3);
        push("s0_done_seen", got1, 1);
        step();
        push("t1_busy_after", busy_v[0], 0);

        // Uploader stalls for 7 cycles on vector 1
        step();
        start = 1'b1; step(); ts = cyc; start = 1'b0;
        wait_result(8'd1, "t2_reach_v1");
        res_ready = 1'b0; bad = 0; nst = 0;
        repeat (7) begin
            step();
            if (!res_valid_v[0] || res_data_v[0] != 8'd20 || res_index_v[0] != 8'd1) bad++;
            if (dut_step_v[0]) nst++;
        end
        res_ready = 1'b1;
        push("t2_hold_stable", bad, 0);
        push("t2_no_step", nst, 0);
        wait_done(ts, 27, "t2_done_at");
        step();
        push("t2_busy_after", busy_v[0], 0);

        // abort during the settle phase of vector 2
        step();
        start = 1'b1; step(); start = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if (dut_step_v[0] && tv_addr_v[0] == 8'd2) found = 1'b1;
                else step();
            end
            if (!found) push("t4_reach_v2_timeout", 0, 1);
        end
        step();
        abort = 1'b1; step(); abort = 1'b0;
        push("t4_res_valid", res_valid_v[0], 0);
        push("t4_busy", busy_v[0], 0);
        push("t4_dut_in_kept", dut_in_v[0], 16'h561E);
        nd = 0;
        repeat (30) begin step(); if (done_v[0]) nd++; end
        push("t4_no_done", nd, 0);
        start = 1'b1; step(); start = 1'b0;
        push("t4_restart_addr", tv_addr_v[0], 0);
        push("t4_restart_busy", busy_v[0], 1);

        // Asynchronous reset between edges while a result is pending
        wait_result(8'd0, "t5_reach_result");
        #2 reset = 1'b1;
        #1;
        push("t5_res_valid_async", res_valid_v[0], 0);
        push("t5_busy_async", busy_v[0], 0);
        start = 1'b1; step(); step();
        start = 1'b0; reset = 1'b0;
        step();
        push("t5_start_ignored", busy_v[0], 0);

        // start mid-run is ignored; abort together with a handshake cancels it
        start = 1'b1; step(); start = 1'b0;
        wait_result(8'd0, "t6_reach_v0");
        start = 1'b1; step(); start = 1'b0;
        push("t6_addr_after_hs", tv_addr_v[0], 1);
        push("t6_busy", busy_v[0], 1);
        wait_result(8'd1, "t6_reach_v1");
        abort = 1'b1; step(); abort = 1'b0;
        push("t6_res_valid", res_valid_v[0], 0);
        push("t6_tv_addr_not_advanced", tv_addr_v[0], 1);
        nd = 0;
        repeat (30) begin step(); if (done_v[0]) nd++; end
        push("t6_no_done", nd, 0);
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        push("t6_start_abort_idle", busy_v[0], 0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
